// File: rtl/crypto_key_pkg.sv
// Shared types and default sizing for the multi-slot crypto key vault.
package crypto_key_pkg;

  localparam int unsigned DefKeyW     = 16;
  localparam int unsigned DefNumSlots = 4;

  typedef enum logic [0:0] {
    StIdle,
    StZero
  } vault_state_e;

endpackage

// File: rtl/crypto_key_vault_if.sv
// Configuration-bus side of the key vault: write, lock and read channels.
interface crypto_key_vault_if #(
  parameter int unsigned KEY_W     = crypto_key_pkg::DefKeyW,
  parameter int unsigned NUM_SLOTS = crypto_key_pkg::DefNumSlots
);
  localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);

  logic              wr_en;
  logic [SLOT_W-1:0] wr_addr;
  logic [KEY_W-1:0]  wr_data;
  logic              wr_err;
  logic              lock_en;
  logic [SLOT_W-1:0] lock_addr;
  logic              rd_en;
  logic [SLOT_W-1:0] rd_addr;
  logic              rd_valid;
  logic [KEY_W-1:0]  rd_data;
  logic              rd_err;

  modport master (
    output wr_en, wr_addr, wr_data, lock_en, lock_addr, rd_en, rd_addr,
    input  wr_err, rd_valid, rd_data, rd_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, lock_en, lock_addr, rd_en, rd_addr,
    output wr_err, rd_valid, rd_data, rd_err
  );

endinterface

// File: rtl/crypto_key_slot.sv
// One key slot: key register plus sticky lock bit and written-since-clear valid bit.
module crypto_key_slot
  import crypto_key_pkg::*;
#(
  parameter int unsigned KEY_W = DefKeyW
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [KEY_W-1:0] wr_data,
  input  logic             lock_set,
  input  logic             clear_key,
  input  logic             clear_all,
  output logic [KEY_W-1:0] key,
  output logic             locked,
  output logic             valid
);

  logic [KEY_W-1:0] key_q;
  logic             locked_q;
  logic             valid_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_q    <= '0;
      locked_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      if (clear_key) begin
        key_q <= '0;
      end else if (wr_en) begin
        key_q <= wr_data;
      end
      if (clear_all) begin
        locked_q <= 1'b0;
        valid_q  <= 1'b0;
      end else begin
        if (lock_set) locked_q <= 1'b1;
        if (wr_en)    valid_q  <= 1'b1;
      end
    end
  end

  assign key    = key_q;
  assign locked = locked_q;
  assign valid  = valid_q;

endmodule

// File: rtl/crypto_key_vault.sv
// Multi-slot key store with sticky per-slot locks, bus read-back, engine key port
// and a one-slot-per-cycle zeroization sequence.
module crypto_key_vault
  import crypto_key_pkg::*;
#(
  parameter int unsigned KEY_W     = DefKeyW,
  parameter int unsigned NUM_SLOTS = DefNumSlots,
  localparam int unsigned SLOT_W   = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 resetn,
  crypto_key_vault_if.slave    bus,
  input  logic [SLOT_W-1:0]    key_sel,
  output logic [KEY_W-1:0]     key_out,
  output logic                 key_valid,
  input  logic                 zeroize,
  output logic                 busy,
  output logic [NUM_SLOTS-1:0] lock_status
);

  localparam logic [SLOT_W-1:0] LastSlot = SLOT_W'(NUM_SLOTS - 1);

  vault_state_e      state_q, state_d;
  logic [SLOT_W-1:0] zcnt_q, zcnt_d;
  logic              clear_all;

  logic [KEY_W-1:0]     slot_key [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_lock;
  logic [NUM_SLOTS-1:0] slot_valid;

  logic             idle, bus_ok, wr_ok, rd_reject;
  logic             wr_err_q, rd_valid_q, rd_err_q, key_valid_q;
  logic [KEY_W-1:0] rd_data_q, key_out_q;

  always_comb begin
    state_d   = state_q;
    zcnt_d    = zcnt_q;
    clear_all = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (zeroize) begin
          state_d = StZero;
          zcnt_d  = '0;
        end
      end
      StZero: begin
        if (zcnt_q == LastSlot) begin
          state_d   = StIdle;
          zcnt_d    = '0;
          clear_all = 1'b1;
        end else begin
          zcnt_d = zcnt_q + SLOT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      zcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      zcnt_q  <= zcnt_d;
    end
  end

  // Zeroize outranks bus writes and locks even in the cycle it is first sampled.
  assign idle      = (state_q == StIdle);
  assign bus_ok    = idle && !zeroize;
  assign wr_ok     = bus.wr_en && bus_ok && !slot_lock[bus.wr_addr];
  assign rd_reject = !idle || slot_lock[bus.rd_addr];

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    crypto_key_slot #(
      .KEY_W(KEY_W)
    ) u_slot (
      .clk      (clk),
      .resetn   (resetn),
      .wr_en    (wr_ok && (bus.wr_addr == SLOT_W'(i))),
      .wr_data  (bus.wr_data),
      .lock_set (bus.lock_en && bus_ok && (bus.lock_addr == SLOT_W'(i))),
      .clear_key(!idle && (zcnt_q == SLOT_W'(i))),
      .clear_all(clear_all),
      .key      (slot_key[i]),
      .locked   (slot_lock[i]),
      .valid    (slot_valid[i])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_err_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
      rd_data_q   <= '0;
      key_valid_q <= 1'b0;
      key_out_q   <= '0;
    end else begin
      wr_err_q    <= bus.wr_en && !wr_ok;
      rd_valid_q  <= bus.rd_en;
      rd_err_q    <= bus.rd_en && rd_reject;
      rd_data_q   <= (bus.rd_en && !rd_reject) ? slot_key[bus.rd_addr] : '0;
      key_valid_q <= bus_ok && slot_valid[key_sel];
      key_out_q   <= (bus_ok && slot_valid[key_sel]) ? slot_key[key_sel] : '0;
    end
  end

  assign bus.wr_err   = wr_err_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_err   = rd_err_q;
  assign bus.rd_data  = rd_data_q;
  assign key_out      = key_out_q;
  assign key_valid    = key_valid_q;
  assign busy         = (state_q == StZero);
  assign lock_status  = slot_lock;

endmodule

// File: tb/tb_crypto_key_vault.sv
// Directed bench for crypto_key_vault: 16x4 instance for protocol checks, 32x8 for fill/readback.
module tb_crypto_key_vault;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  crypto_key_vault_if #(.KEY_W(16), .NUM_SLOTS(4)) bus4 ();
  crypto_key_vault_if #(.KEY_W(32), .NUM_SLOTS(8)) bus8 ();

  logic [1:0]  key_sel4;
  logic [15:0] key_out4;
  logic        key_valid4, zeroize4, busy4;
  logic [3:0]  lock_status4;

  logic [2:0]  key_sel8;
  logic [31:0] key_out8;
  logic        key_valid8, zeroize8, busy8;
  logic [7:0]  lock_status8;

  crypto_key_vault #(.KEY_W(16), .NUM_SLOTS(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus4),
    .key_sel    (key_sel4),
    .key_out    (key_out4),
    .key_valid  (key_valid4),
    .zeroize    (zeroize4),
    .busy       (busy4),
    .lock_status(lock_status4)
  );

  crypto_key_vault #(.KEY_W(32), .NUM_SLOTS(8)) dut8 (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus8),
    .key_sel    (key_sel8),
    .key_out    (key_out8),
    .key_valid  (key_valid8),
    .zeroize    (zeroize8),
    .busy       (busy8),
    .lock_status(lock_status8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write4(input logic [1:0] a, input logic [15:0] d, input logic exp_err,
                        input string tag);
    bus4.wr_en = 1'b1; bus4.wr_addr = a; bus4.wr_data = d;
    tick();
    bus4.wr_en = 1'b0;
    check_eq(tag, bus4.wr_err, exp_err);
  endtask

  task automatic read4(input logic [1:0] a, input logic [15:0] exp_d, input logic exp_err,
                       input string tag);
    bus4.rd_en = 1'b1; bus4.rd_addr = a;
    tick();
    bus4.rd_en = 1'b0;
    check_eq({tag, "_valid"}, bus4.rd_valid, 1'b1);
    check_eq({tag, "_data"}, bus4.rd_data, exp_d);
    check_eq({tag, "_err"}, bus4.rd_err, exp_err);
  endtask

  initial begin
    int busy_cnt;
    logic [31:0] exp8;

    bus4.wr_en = 0; bus4.wr_addr = 0; bus4.wr_data = 0; bus4.lock_en = 0; bus4.lock_addr = 0;
    bus4.rd_en = 0; bus4.rd_addr = 0;
    bus8.wr_en = 0; bus8.wr_addr = 0; bus8.wr_data = 0; bus8.lock_en = 0; bus8.lock_addr = 0;
    bus8.rd_en = 0; bus8.rd_addr = 0;
    key_sel4 = 0; zeroize4 = 0; key_sel8 = 0; zeroize8 = 0;

    // Reset state
    tick(); tick();
    check_eq("rst_key_out", key_out4, 16'h0);
    check_eq("rst_key_valid", key_valid4, 1'b0);
    check_eq("rst_busy", busy4, 1'b0);
    check_eq("rst_lock_status", lock_status4, 4'h0);
    check_eq("rst_rd_valid", bus4.rd_valid, 1'b0);
    check_eq("rst_wr_err", bus4.wr_err, 1'b0);
    resetn = 1'b1;
    tick();

    // Basic write / read / engine port
    key_sel4 = 2'd2;
    write4(2'd2, 16'hA5A5, 1'b0, "wr_slot2");
    read4(2'd2, 16'hA5A5, 1'b0, "rd_slot2");
    check_eq("key_out_slot2", key_out4, 16'hA5A5);
    check_eq("key_valid_slot2", key_valid4, 1'b1);
    tick();
    check_eq("rd_valid_pulse", bus4.rd_valid, 1'b0);

    // Lock slot 2: writes rejected, bus read rejected, engine still sees key
    bus4.lock_en = 1'b1; bus4.lock_addr = 2'd2;
    tick();
    bus4.lock_en = 1'b0;
    check_eq("lock_status_2", lock_status4, 4'b0100);
    write4(2'd2, 16'h1234, 1'b1, "wr_locked_err");
    read4(2'd2, 16'h0000, 1'b1, "rd_locked");
    check_eq("wr_err_one_cycle", bus4.wr_err, 1'b0);
    check_eq("key_out_locked", key_out4, 16'hA5A5);

    // Same-cycle write and lock of slot 1
    key_sel4 = 2'd1;
    bus4.lock_en = 1'b1; bus4.lock_addr = 2'd1;
    write4(2'd1, 16'hBEEF, 1'b0, "wr_lock_same");
    bus4.lock_en = 1'b0;
    check_eq("lock_status_21", lock_status4, 4'b0110);
    read4(2'd1, 16'h0000, 1'b1, "rd_slot1_locked");
    check_eq("key_out_slot1", key_out4, 16'hBEEF);
    check_eq("key_valid_slot1", key_valid4, 1'b1);

    write4(2'd0, 16'h3C3C, 1'b0, "wr_slot0");
    write4(2'd3, 16'h0F0F, 1'b0, "wr_slot3");
    read4(2'd3, 16'h0F0F, 1'b0, "rd_slot3");

    // Zeroize: busy for exactly 4 cycles, bus rejected meanwhile
    zeroize4 = 1'b1;
    tick();
    zeroize4 = 1'b0;
    check_eq("zero_busy_rise", busy4, 1'b1);
    check_eq("zero_key_valid", key_valid4, 1'b0);
    check_eq("zero_key_out", key_out4, 16'h0);
    bus4.wr_en = 1'b1; bus4.wr_addr = 2'd0; bus4.wr_data = 16'h7777;
    bus4.rd_en = 1'b1; bus4.rd_addr = 2'd3;
    zeroize4 = 1'b1;  // ignored while busy
    busy_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (busy4) busy_cnt++;
      tick();
      if (k == 0) begin
        bus4.wr_en = 1'b0; bus4.rd_en = 1'b0; zeroize4 = 1'b0;
        check_eq("zero_wr_err", bus4.wr_err, 1'b1);
        check_eq("zero_rd_err", bus4.rd_err, 1'b1);
        check_eq("zero_rd_data", bus4.rd_data, 16'h0);
      end
    end
    check_eq("zero_busy_cycles", busy_cnt, 4);
    check_eq("zero_lock_status", lock_status4, 4'h0);
    for (int i = 0; i < 4; i++) read4(2'(i), 16'h0000, 1'b0, "rd_after_zero");
    check_eq("zero_key_valid_after", key_valid4, 1'b0);
    check_eq("zero_key_out_after", key_out4, 16'h0);

    // Reset during zeroize cycle 2
    write4(2'd0, 16'h1111, 1'b0, "wr_pre_rst");
    bus4.lock_en = 1'b1; bus4.lock_addr = 2'd3;
    tick();
    bus4.lock_en = 1'b0;
    zeroize4 = 1'b1;
    tick();
    zeroize4 = 1'b0;
    tick();
    check_eq("rst_mid_busy_before", busy4, 1'b1);
    resetn = 1'b0;
    #1;
    check_eq("rst_mid_busy", busy4, 1'b0);
    check_eq("rst_mid_lock_status", lock_status4, 4'h0);
    check_eq("rst_mid_key_out", key_out4, 16'h0);
    #2;
    resetn = 1'b1;
    tick();
    write4(2'd0, 16'h5A5A, 1'b0, "wr_after_rst");
    read4(2'd0, 16'h5A5A, 1'b0, "rd_after_rst");

    // 8 slots x 32 bits: fill and read back
    for (int i = 0; i < 8; i++) begin
      bus8.wr_en = 1'b1; bus8.wr_addr = 3'(i); bus8.wr_data = 32'hA000_0000 + i * 32'h0101_0101;
      tick();
      bus8.wr_en = 1'b0;
      check_eq("wr8_err", bus8.wr_err, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      exp8 = 32'hA000_0000 + i * 32'h0101_0101;
      bus8.rd_en = 1'b1; bus8.rd_addr = 3'(i);
      tick();
      check_eq("rd8_valid", bus8.rd_valid, 1'b1);
      check_eq("rd8_data", bus8.rd_data, exp8);
      check_eq("rd8_err", bus8.rd_err, 1'b0);
    end
    bus8.rd_en = 1'b0;
    key_sel8 = 3'd7;
    tick(); tick();
    check_eq("key8_out", key_out8, 32'hA707_0707);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crypto_key_vault.md
# crypto_key_vault

Parametrised multi-slot key store that replaces the single-register key store in the crypto subsystem. Holds NUM_SLOTS keys of KEY_W bits behind a bus-side write/read port and a separate engine-side key port. Adds per-slot sticky write/read locks, per-slot valid tracking, and a multi-cycle zeroization sequence. Sits between the configuration bus and the cipher engines.

## Interface
- KEY_W, 16, key width in bits (≥ 8)
- NUM_SLOTS, 4, number of key slots (2..16)
- SLOT_W, $clog2(NUM_SLOTS), slot index width (derived, not overridden)
- clk  in  1  single clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- wr_en  in  1  bus write strobe
- wr_addr  in  SLOT_W  write slot index
- wr_data  in  KEY_W  key value
- wr_err  out  1  one-cycle pulse: previous-cycle write rejected
- lock_en  in  1  lock strobe (sticky lock of lock_addr)
- lock_addr  in  SLOT_W  slot to lock
- rd_en  in  1  bus read strobe
- rd_addr  in  SLOT_W  read slot index
- rd_valid  out  1  one-cycle pulse, read response
- rd_data  out  KEY_W  read data (0 when rejected)
- rd_err  out  1  with rd_valid: read rejected
- key_sel  in  SLOT_W  engine slot select
- key_out  out  KEY_W  registered engine key
- key_valid  out  1  selected slot written since last zeroize/reset
- zeroize  in  1  start zeroization
- busy  out  1  zeroization in progress
- lock_status  out  NUM_SLOTS  per-slot lock bits

## Operation
- Reset (resetn low, async): all slots, lock bits, valid bits, FSM -> IDLE; every output 0.
- FSM states: IDLE, ZERO. IDLE -> ZERO on zeroize. ZERO clears slot zcnt (0..NUM_SLOTS-1), one slot per cycle; at zcnt = NUM_SLOTS-1 clears all lock and valid bits, returns to IDLE. zeroize asserted during ZERO ignored (no restart).
- Write: accepted in IDLE when slot unlocked and zeroize low; slot <- wr_data, valid bit set. Otherwise dropped, wr_err pulses next cycle.
- Lock: in IDLE sets lock bit of lock_addr; ignored in ZERO; locking a locked slot is a no-op. Locks only cleared by zeroize or reset.
- Same-cycle write and lock of same unlocked slot: write lands, then slot locked (write-then-lock).
- Read: unlocked slot -> rd_data = contents, rd_err 0. Locked slot, or any read while busy -> rd_data 0, rd_err 1. Reads always complete (rd_valid pulses).
- Engine port: key_out = slot[key_sel] regardless of lock (locked keys usable, not bus-readable). Slot not valid -> key_out 0, key_valid 0. During ZERO key_out = 0, key_valid = 0.
- Priority within a cycle: reset > zeroize > lock/write > read. Read of a slot written same cycle returns old value.

## Timing
- Write, lock: effective at the clock edge they are sampled on; visible to reads issued next cycle.
- Read: rd_valid/rd_data/rd_err one cycle after rd_en; back-to-back reads every cycle.
- wr_err: one cycle after the rejected wr_en.
- Engine port: key_out/key_valid registered, one-cycle latency from key_sel.
- Zeroize: busy rises the cycle after zeroize is sampled, stays high exactly NUM_SLOTS cycles; writes accepted again the cycle busy falls.
- lock_status: registered, reflects lock bits with no extra delay.
- Reset mid-zeroize: immediate return to IDLE, all state cleared.

## Structure
- Package crypto_key_pkg: FSM state enum (IDLE, ZERO), default KEY_W/NUM_SLOTS constants.
- Sub-module crypto_key_slot: one slot register + lock bit + valid bit, with write/lock/clear inputs; generate-instantiated NUM_SLOTS times. Top holds FSM, zcnt, read and engine muxes.

## Test plan
- Reset, then write 16'hA5A5 to slot 2, read slot 2 -> rd_valid next cycle, rd_data 16'hA5A5, rd_err 0; key_sel=2 -> key_out 16'hA5A5, key_valid 1.
- Lock slot 2, write 16'h1234 to slot 2 -> wr_err pulse, read slot 2 -> rd_data 0, rd_err 1; key_out still 16'hA5A5; lock_status = 4'b0100.
- Same-cycle write 16'hBEEF + lock slot 1 -> key_sel=1 gives 16'hBEEF, bus read rejected.
- zeroize with NUM_SLOTS=4 -> busy high exactly 4 cycles; write during busy gets wr_err; afterwards all slots read 0, lock_status 0, key_valid 0.
- resetn low during ZERO cycle 2 -> busy 0 and all outputs 0 at once; after release slot 0 writes accepted.
- NUM_SLOTS=8, KEY_W=32: fill all slots with index-derived values, read back all -> exact match, no errors.
